spi_reg_ctrl: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_reg_ctrl_sync.sv | 28 ++
 rtl/spi_reg_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI command/register controller.
//   state_e      : controller FSM states
//   CMD_RW_BIT   : bit of the command byte that selects read (1) / write (0)
//   SPI_WORD_W   : SPI shift word width the controller is built around
//   SYNC_STAGES  : depth of the slave-select synchronizer
package spi_reg_pkg;

  localparam int CMD_RW_BIT  = 7;
  localparam int SPI_WORD_W  = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_FETCH,
    ST_CAPTURE,
    ST_LOAD,
    ST_RWAIT
  } state_e;

endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// Generic single-bit multi-flop synchronizer with selectable reset value.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, loads RST_VAL into every stage
//   d_i  : asynchronous input
//   q_o  : synchronized output
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller between spi_slave and a register bank.
// The first byte of each slave-select frame is {rw, addr[6:0]}; writes
// stream data bytes to consecutive addresses, reads fetch consecutive
// registers and stage them into the slave's TX buffer.
//   clk, rst            : system clock, asynchronous active-high reset
//   ss                  : raw active-low slave select (asynchronous)
//   rx_buffer, rx_dv    : received byte and its one-cycle valid pulse
//   tx_halt             : slave is shifting; TX load refused while high
//   tx_buffer, wr       : byte to transmit and its load request
//   spi_rst             : one-cycle pulse at frame end to clear the slave
//   reg_addr/wdata/we/re: register bus; reg_rdata valid the cycle after re
//   busy                : frame active
//   ovr                 : sticky read overrun, cleared at next frame start
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic [DATA_W-1:0] rx_buffer,
  input  logic              rx_dv,
  input  logic              tx_halt,
  output logic [DATA_W-1:0] tx_buffer,
  output logic              wr,
  output logic              spi_rst,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              ovr
);

  localparam logic [1:0] WARM_DONE = 2'(SYNC_STAGES);

  logic              ss_s;
  logic              ss_prev_q;
  logic [1:0]        warm_q;
  logic              armed_q;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              spi_rst_q;
  logic              we_q;
  logic              re_q;
  logic              busy_q;
  logic              ovr_q;
  logic              frame_start_d;
  logic              frame_end_d;

  sync_2ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ss),
    .q_o (ss_s)
  );

  // The synchronizer output only reflects the real pin after it has been
  // refilled post-reset. Frames are accepted only once ss_s has been seen
  // high after that point, so a frame already running at reset release
  // (whose falling edge is an artefact of the reset value) is ignored.
  assign frame_start_d = armed_q & ss_prev_q & ~ss_s;
  assign frame_end_d   = ~ss_prev_q & ss_s;
  assign addr_inc_d    = addr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_prev_q <= 1'b1;
      warm_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      spi_rst_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ss_prev_q <= ss_s;
      if (warm_q != WARM_DONE) warm_q <= warm_q + 2'd1;
      if ((warm_q == WARM_DONE) && ss_s) armed_q <= 1'b1;

      we_q      <= 1'b0;
      re_q      <= 1'b0;
      spi_rst_q <= 1'b0;

      // Frame end overrides everything, including a byte arriving in the
      // same cycle and any strobe that byte would have caused.
      if ((state_q != ST_IDLE) && frame_end_d) begin
        state_q   <= ST_IDLE;
        wr_q      <= 1'b0;
        busy_q    <= 1'b0;
        spi_rst_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (frame_start_d) begin
              state_q <= ST_CMD;
              busy_q  <= 1'b1;
              ovr_q   <= 1'b0;
            end
          end
          ST_CMD: begin
            if (rx_dv) begin
              addr_q <= rx_buffer[ADDR_W-1:0];
              if (rx_buffer[CMD_RW_BIT]) begin
                re_q    <= 1'b1;
                state_q <= ST_FETCH;
              end else begin
                state_q <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            // Address advances the cycle after the strobe it belonged to.
            if (we_q) addr_q <= addr_inc_d;
            if (rx_dv) begin
              we_q    <= 1'b1;
              wdata_q <= rx_buffer;
            end
          end
          ST_FETCH: begin
            if (rx_dv) ovr_q <= 1'b1;
            state_q <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (rx_dv) ovr_q <= 1'b1;
            tx_q    <= reg_rdata;
            wr_q    <= 1'b1;
            state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            if (rx_dv) ovr_q <= 1'b1;
            if (!tx_halt) begin
              wr_q    <= 1'b0;
              addr_q  <= addr_inc_d;
              state_q <= ST_RWAIT;
            end
          end
          ST_RWAIT: begin
            if (rx_dv) begin
              re_q    <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_buffer = tx_q;
  assign wr        = wr_q;
  assign spi_rst   = spi_rst_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: transaction-level frames with
// randomized data, addresses and tx_halt, compared to an event list built
// from the command/burst rules.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic [7:0] rx_buffer;
  logic       rx_dv;
  logic       tx_halt;
  logic [7:0] tx_buffer;
  logic       wr;
  logic       spi_rst;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_q[$];
  int exp_q[$];
  int rst_cnt  = 0;
  int both_cnt = 0;

  spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .rx_buffer (rx_buffer),
    .rx_dv     (rx_dv),
    .tx_halt   (tx_halt),
    .tx_buffer (tx_buffer),
    .wr        (wr),
    .spi_rst   (spi_rst),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  function automatic int ev(input int kind, input int addr, input int data);
    return (kind << 16) | (addr << 8) | data;
  endfunction

  function automatic int reg_val(input int addr);
    return (addr & 8'h7F) ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register bank stub: data only valid the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= 8'(reg_val(int'(reg_addr)));
    else        reg_rdata <= 8'($urandom);
  end

  // Bus activity log: 1 = write, 2 = read strobe, 3 = accepted TX load.
  always @(negedge clk) begin
    if (reg_we)           obs_q.push_back(ev(1, int'(reg_addr), int'(reg_wdata)));
    if (reg_re)           obs_q.push_back(ev(2, int'(reg_addr), 0));
    if (wr && !tx_halt)   obs_q.push_back(ev(3, int'(reg_addr), int'(tx_buffer)));
    if (spi_rst)          rst_cnt <= rst_cnt + 1;
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
  end

  // tx_halt: random, but guaranteed low at least every fourth cycle.
  initial begin
    int c;
    c = 0;
    tx_halt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      tx_halt = ((c % 4) == 3) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_buffer = b;
    rx_dv     = 1'b1;
    tick(1);
    rx_dv     = 1'b0;
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_nevents"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, obs_q[i], exp_q[i]);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input int nd,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input bit ovr_inj, input bit coincide, input bit idle_byte);
    logic [6:0] a;
    logic [7:0] d;
    int         rst0;
    int         both0;
    obs_q.delete();
    exp_q.delete();
    if (idle_byte) begin
      send_byte(8'($urandom));
      tick(3);
    end
    ss = 1'b0;
    tick(4);
    chk("busy_start", busy, 1);
    chk("ovr_clear", ovr, 0);
    a = cmd[6:0];
    send_byte(cmd);
    if (!cmd[7]) begin
      tick(11);
      for (int i = 0; i < nd; i++) begin
        d = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom);
        exp_q.push_back(ev(1, int'(a), int'(d)));
        send_byte(d);
        chk("we_t1", reg_we, 1);
        chk("waddr_t1", reg_addr, a);
        chk("wdata_t1", reg_wdata, d);
        tick(1);
        a = a + 7'd1;
        chk("waddr_t2", reg_addr, a);
        tick($urandom_range(10, 18));
      end
    end else begin
      for (int k = 0; k <= nd; k++) begin
        if (k > 0) send_byte(8'($urandom));
        exp_q.push_back(ev(2, int'(a), 0));
        exp_q.push_back(ev(3, int'(a), reg_val(int'(a))));
        chk("re_t1", reg_re, 1);
        chk("raddr_t1", reg_addr, a);
        if (ovr_inj && k == 0) begin
          tick(1);
          send_byte(8'($urandom));
          chk("ovr_set", ovr, 1);
        end else begin
          tick(2);
        end
        chk("wr_t3", wr, 1);
        chk("tx_t3", tx_buffer, reg_val(int'(a)));
        a = a + 7'd1;
        tick($urandom_range(12, 20));
      end
    end
    chk("ovr_hold", ovr, ovr_inj);
    rst0  = rst_cnt;
    both0 = both_cnt;
    ss = 1'b1;
    if (coincide) begin
      // ss_s rises two edges later; the byte lands in the frame-end cycle.
      tick(2);
      send_byte(8'($urandom));
      tick(4);
    end else begin
      tick(6);
    end
    chk("spi_rst_pulse", rst_cnt - rst0, 1);
    chk("busy_end", busy, 0);
    chk("wr_end", wr, 0);
    chk("ovr_sticky", ovr, ovr_inj);
    chk("we_re_excl", both_cnt - both0, 0);
    compare_events("events");
  endtask

  initial begin
    logic [7:0] cmd;
    rst       = 1'b1;
    ss        = 1'b1;
    rx_dv     = 1'b0;
    rx_buffer = 8'h00;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr, 0);
    chk("rst_tx", tx_buffer, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_spi_rst", spi_rst, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    rst = 1'b0;
    tick(5);

    do_frame(8'h05, 2, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);   // write burst
    do_frame(8'h82, 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);   // read burst
    do_frame(8'h7F, 2, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);   // write wrap
    do_frame(8'hFF, 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);   // read wrap
    do_frame(8'h10, 1, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0);   // abort mid byte
    do_frame(8'h20, 1, 8'h77, 8'h00, 1'b0, 1'b1, 1'b1);   // end + rx_dv together
    do_frame(8'h83, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);   // overrun
    do_frame(8'h30, 1, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);   // ovr clears

    // Reset in the middle of a read with ss held low.
    obs_q.delete();
    ss = 1'b0;
    tick(4);
    send_byte(8'h85);
    tick(1);
    send_byte(8'hEE);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", wr, 0);
    chk("mid_rst_tx", tx_buffer, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_re", reg_re, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    tick(10);
    send_byte(8'h03);
    tick(12);
    send_byte(8'h11);
    tick(12);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_events", obs_q.size(), 0);
    ss = 1'b1;
    tick(6);
    do_frame(8'h44, 2, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'h7E | 7'($urandom_range(0, 1));
      do_frame(cmd, $urandom_range(0, 3), 8'($urandom), 8'($urandom),
               cmd[7] & 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
